// File: rtl/div_pkg.sv
// div_pkg: shared state encoding, default width and counter sizing for seq_divider
package div_pkg;
  localparam int DEF_WIDTH = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);
  logic [WIDTH:0] sh;
  assign sh    = {rem_i, bit_i};
  assign q_o   = sh >= {1'b0, div_i};
  assign rem_o = q_o ? WIDTH'(sh - {1'b0, div_i}) : sh[WIDTH-1:0];
endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per clock; DIVIDER_SIGNED_EN enables two's-complement operands
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = cnt_w(WIDTH);
  state_e state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d, d_q, d_d, r_q, r_d, quo_q, quo_d, rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic dz_q, dz_d, dbz_q, dbz_d;
  logic [WIDTH-1:0] r_step, q_res, r_src, a_mag, b_mag, q_fix, r_fix, dz_quo;
  logic q_bit, accept, finish;
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i(r_q),
    .bit_i(q_q[WIDTH-1]),
    .div_i(d_q),
    .rem_o(r_step),
    .q_o  (q_bit)
  );
  assign accept = start && state_q != RUN;
  assign finish = state_q == RUN && (dz_q || cnt_q == CW'(WIDTH - 1));
  assign q_res  = {q_q[WIDTH-2:0], q_bit};
  // a zero divisor finishes before any step, so q_q still holds the dividend magnitude
  assign r_src  = dz_q ? q_q : r_step;
`ifdef DIVIDER_SIGNED_EN
  logic qneg_q, rneg_q, qneg_d, rneg_d;
  assign a_mag  = in_1[WIDTH-1] ? -in_1 : in_1;
  assign b_mag  = in_2[WIDTH-1] ? -in_2 : in_2;
  assign qneg_d = accept ? in_1[WIDTH-1] ^ in_2[WIDTH-1] : qneg_q;
  assign rneg_d = accept ? in_1[WIDTH-1] : rneg_q;
  assign q_fix  = qneg_q ? -q_res : q_res;
  assign r_fix  = rneg_q ? -r_src : r_src;
  assign dz_quo = rneg_q ? WIDTH'(1) : '1;
  always_ff @(posedge clk) begin
    if (rst) begin
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
    end
  end
`else
  assign a_mag  = in_1;
  assign b_mag  = in_2;
  assign q_fix  = q_res;
  assign r_fix  = r_src;
  assign dz_quo = '1;
`endif
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    d_d     = d_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    if (accept) begin
      state_d = RUN;
      q_d     = a_mag;
      d_d     = b_mag;
      r_d     = '0;
      cnt_d   = '0;
      dz_d    = in_2 == '0;
    end else if (state_q == RUN) begin
      q_d   = q_res;
      r_d   = r_step;
      cnt_d = cnt_q + CW'(1);
      if (finish) begin
        state_d = DONE;
        quo_d   = dz_q ? dz_quo : q_fix;
        rem_d   = r_fix;
        dbz_d   = dz_q;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      d_q     <= d_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end
  assign busy        = state_q == RUN;
  assign done        = state_q == DONE;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: arithmetic reference model compared every cycle plus hand-computed directed vectors
module tb_seq_divider;
  localparam int W = 8;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [W-1:0] in_1 = '0, in_2 = '0;
  logic busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;
  int checks = 0, errors = 0;
  logic m_run = 1'b0, m_done = 1'b0, m_z = 1'b0;
  int m_left = 0;
  logic [W-1:0] m_q = '0, m_r = '0, m_a = '0, m_b = '0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_1(in_1), .in_2(in_2),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef DIVIDER_SIGNED_EN
    int ia = $signed(a);
    int ib = $signed(b);
    if (ib == 0) return {(ia < 0 ? W'(1) : {W{1'b1}}), a};
    return {W'(ia / ib), W'(ia % ib)};
`else
    if (b == '0) return {{W{1'b1}}, a};
    return {a / b, a % b};
`endif
  endfunction

  // cycle-level model: accepted ops take W clocks (1 for zero divisor), then one done cycle
  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_run = 0; m_done = 0; m_left = 0; m_q = '0; m_r = '0; m_z = 0;
    end else if (m_run) begin
      m_left--;
      if (m_left == 0) begin
        m_run = 0;
        m_done = 1;
        {m_q, m_r} = ref_div(m_a, m_b);
        m_z = m_b == '0;
      end
    end else begin
      m_done = 0;
      if (start) begin
        m_a = in_1; m_b = in_2; m_run = 1;
        m_left = in_2 == '0 ? 1 : W;
      end
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("busy", busy, m_run);
      chk("done", done, m_done);
      chk("quotient", quotient, m_q);
      chk("remainder", remainder, m_r);
      chk("div_by_zero", div_by_zero, m_z);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input int lat,
                    input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
    int n;
    in_1 = a; in_2 = b; start = 1;
    @(negedge clk);
    start = 0; in_1 = ~a; in_2 = b + 3;
    n = 1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, lat);
    chk("op_q", quotient, eq);
    chk("op_r", remainder, er);
    chk("op_z", div_by_zero, ez);
    repeat (3) @(negedge clk);
    chk("hold_q", quotient, eq);
    chk("hold_r", remainder, er);
  endtask

  logic [W-1:0] ba[3] = '{8'd50, 8'd77, 8'd9};
  logic [W-1:0] bb[3] = '{8'd3, 8'd10, 8'd0};
  logic [W-1:0] bq[3] = '{8'd16, 8'd7, 8'd255};
  logic [W-1:0] br[3] = '{8'd2, 8'd7, 8'd9};

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_z", div_by_zero, 0);
    rst = 0;
    @(negedge clk);
`ifdef DIVIDER_SIGNED_EN
    op(8'd200, 8'd7, 9, 8'd248, 8'd0, 0);
`else
    op(8'd200, 8'd7, 9, 8'd28, 8'd4, 0);
`endif
    op(8'd5, 8'd0, 2, 8'd255, 8'd5, 1);
    op(8'd255, 8'd1, 9, 8'd255, 8'd0, 0);
    op(8'd6, 8'd200, 9, 8'd0, 8'd6, 0);
    op(8'd0, 8'd5, 9, 8'd0, 8'd0, 0);
    start = 1;
    for (int i = 0; i < 3; i++) begin
      in_1 = ba[i]; in_2 = bb[i];
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!done && n < 40);
      chk("b2b_lat", n, bb[i] == '0 ? 2 : 9);
      chk("b2b_q", quotient, bq[i]);
      chk("b2b_r", remainder, br[i]);
    end
    start = 0;
    repeat (2) @(negedge clk);
    in_1 = 8'd100; in_2 = 8'd7; start = 1;
    @(negedge clk);
    start = 0;
    repeat (2) @(negedge clk);
    in_1 = 8'd1; in_2 = 8'd1; start = 1;
    @(negedge clk);
    start = 0;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("ign_q", quotient, 14);
    chk("ign_r", remainder, 2);
    repeat (2) @(negedge clk);
    in_1 = 8'd123; in_2 = 8'd4; start = 1;
    @(negedge clk);
    start = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_busy", busy, 0);
    chk("abort_q", quotient, 0);
    chk("abort_r", remainder, 0);
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("abort_no_done", n, 0);
    op(8'd100, 8'd9, 9, 8'd11, 8'd1, 0);
`ifdef DIVIDER_SIGNED_EN
    op(8'd249, 8'd2, 9, 8'd253, 8'd255, 0);
    op(8'd7, 8'd254, 9, 8'd253, 8'd1, 0);
    op(8'd128, 8'd255, 9, 8'd128, 8'd0, 0);
    op(8'd249, 8'd0, 2, 8'd1, 8'd249, 1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle restoring unsigned integer divider; the inverse operation of the team's combinational multipliers.
- Used by the neural-network datapath for normalisation and averaging (e.g. sum / count).
- Start/done handshake; resolves one quotient bit per clock.
- Operands and results use the same in/out naming style as the multiplier blocks.

Parameters:
- WIDTH, 8, bit width of dividend, divisor, quotient and remainder (legal range 2..32).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when state is IDLE or DONE
- in_1  input  WIDTH  dividend; captured on the accepting edge
- in_2  input  WIDTH  divisor; captured on the accepting edge
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; results valid in that cycle
- quotient  output  WIDTH  result quotient, held until the next accepted start
- remainder  output  WIDTH  result remainder, held until the next accepted start
- div_by_zero  output  1  set with done when the captured divisor == 0; held with the results

Behaviour:
- Reset: one clock high on rst forces state IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, and internal registers are cleared. Reset overrides start. Reset mid-RUN aborts the division with no done pulse.
- States:
  - IDLE --start--> RUN, or DONE if divisor==0.
  - RUN --bit counter reaches WIDTH--> DONE.
  - DONE --start--> RUN/DONE (back-to-back accepted), else IDLE.
- Accept: when start=1 on edge k in IDLE or DONE:
  - Capture in_1 into the dividend/quotient shift register, in_2 into the divisor register.
  - Clear the partial remainder (WIDTH+1 bits) and the counter.
- RUN step (one per edge):
  - R = {R[WIDTH-1:0], Q[WIDTH-1]}; Q shifts left.
  - If R >= D, then R = R - D and Q[0]=1; else Q[0]=0.
  - Unsigned, no overflow possible.
- Latency: WIDTH steps on edges k+1..k+WIDTH; done=1 in the cycle after edge k+WIDTH; busy=1 from edge k until edge k+WIDTH.
- Results: quotient and remainder outputs update only on the transition into DONE; they are stable between operations.
- Divide by zero: skip RUN; DONE is entered on edge k+1 with quotient = all ones, remainder = dividend, div_by_zero=1.
- Ignored start: start while busy is ignored; it is not queued.
- Operand stability: in_1/in_2 changes after the accept edge have no effect.
- done stays 0 in every cycle other than the single DONE cycle.

Optional Feature:
- Macro: DIVIDER_SIGNED_EN.
- Defined:
  - Operands are two's complement.
  - Magnitudes are taken at accept; the unsigned core runs unchanged.
  - Quotient is negated if the operand signs differ, truncating toward zero.
  - Remainder takes the sign of the dividend.
  - Latency is identical.
  - Most-negative / -1 returns quotient = most-negative and remainder 0, with no flag.
  - Divide by zero returns quotient = -1 if dividend >= 0, else +1, and remainder = dividend.
- Undefined: pure unsigned behaviour as above; the sign logic is absent from the netlist.

Decomposition:
- Shared package/include (div_pkg):
  - State encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Default WIDTH.
  - Counter width function clog2(WIDTH+1).
- One natural sub-module, div_step: combinational single restoring step.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: new remainder, quotient bit.
- seq_divider holds the FSM, registers and optional sign handling.

Test Plan:
- Nominal: WIDTH=8, in_1=200, in_2=7, start pulse -> done exactly 8 edges after accept, quotient=28, remainder=4, div_by_zero=0; busy high 8 cycles.
- Edge operands: 255/1 -> 255 r0; 6/200 -> 0 r6; 0/5 -> 0 r0. Check each result is held after done until the next start.
- Divide by zero: 5/0 -> done 1 edge after accept, quotient=255, remainder=5, div_by_zero=1; the next valid op clears the flag.
- Handshake: start held high continuously with new operands each result -> back-to-back ops accepted in DONE. A start pulse mid-RUN is ignored and the results match the first operands.
- Reset mid-operation: assert rst 3 cycles after accept -> no done, outputs zero, IDLE. A fresh 100/9 then gives 11 r1.
- DIVIDER_SIGNED_EN defined:
  - -7/2 -> q=-3 r=-1.
  - 7/-2 -> q=-3 r=1.
  - -128/-1 -> q=-128 r=0.
